// File: rtl/gcm_pkg.sv
// Shared GF(2^128) constants and FSM encoding for the GHASH multiplier.
// Vectors use GCM bit order: index 0 is the x^0 coefficient and the leftmost hex digit.
package gcm_pkg;

  localparam int GF128_W = 128;

  localparam logic [0:GF128_W-1] GF_R = {8'hE1, 120'd0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } gf_state_t;

endpackage

// File: rtl/gf128_digit_step.sv
// Combinational GF(2^128) digit step: folds DIGIT bits of X into Z and advances V.
// Zero latency; no flow control, the caller registers Z and V.
module gf128_digit_step
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [0:GF128_W-1] i_z,
  input  logic [0:GF128_W-1] i_v,
  input  logic [0:DIGIT-1]   i_x,
  output logic [0:GF128_W-1] o_z,
  output logic [0:GF128_W-1] o_v
);

  logic [0:GF128_W-1] w_z;
  logic [0:GF128_W-1] w_v;

  // V is multiplied by x each step; the x^128 term folds back through R.
  always_comb begin
    w_z = i_z;
    w_v = i_v;
    for (int j = 0; j < DIGIT; j++) begin
      if (i_x[j]) w_z = w_z ^ w_v;
      w_v = {1'b0, w_v[0:GF128_W-2]} ^ (w_v[GF128_W-1] ? GF_R : '0);
    end
  end

  assign o_z = w_z;
  assign o_v = w_v;

endmodule

// File: rtl/gfmul_digit_serial.sv
// Digit-serial GF(2^128) multiplier with GHASH accumulator Y <= (X ^ Y) * H.
// Accept to oValid is 128/DIGIT+1 clocks; result holds while iReady is low, oReady only in IDLE.
module gfmul_digit_serial
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iValid,
  output logic               oReady,
  input  logic [0:GF128_W-1] iX,
  input  logic [0:GF128_W-1] iH,
  input  logic               iAccum,
  input  logic               iClear,
  output logic               oValid,
  input  logic               iReady,
  output logic [0:GF128_W-1] oResult
);

  localparam int LAT   = GF128_W / DIGIT;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  gf_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [0:GF128_W-1] r_x;
  logic [0:GF128_W-1] r_v;
  logic [0:GF128_W-1] r_z;
  logic [0:GF128_W-1] r_y;

  logic [0:GF128_W-1] w_ysel;
  logic [0:GF128_W-1] w_operand;
  logic [0:DIGIT-1]   w_xd;
  logic [0:GF128_W-1] w_z;
  logic [0:GF128_W-1] w_v;

  assign w_ysel    = iClear ? '0 : r_y;
  assign w_operand = iAccum ? (iX ^ w_ysel) : iX;
  // Xr is shifted toward index 0 each cycle, so the current digit is always at the front.
  assign w_xd      = r_x[0:DIGIT-1];

  gf128_digit_step #(
    .DIGIT (DIGIT)
  ) u_step (
    .i_z (r_z),
    .i_v (r_v),
    .i_x (w_xd),
    .o_z (w_z),
    .o_v (w_v)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_v     <= '0;
      r_z     <= '0;
      r_y     <= '0;
      oReady  <= 1'b1;
      oValid  <= 1'b0;
      oResult <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (iValid) begin
            r_x     <= w_operand;
            r_v     <= iH;
            r_z     <= '0;
            r_cnt   <= '0;
            oReady  <= 1'b0;
            r_state <= ST_BUSY;
          end else if (iClear) begin
            r_y <= '0;
          end
        end
        ST_BUSY: begin
          r_z   <= w_z;
          r_v   <= w_v;
          r_x   <= r_x << DIGIT;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle publishes Z; a clear in that same cycle wins over the Y update.
          if (!oValid) begin
            oResult <= r_z;
            oValid  <= 1'b1;
            r_y     <= iClear ? '0 : r_z;
          end else begin
            if (iClear) r_y <= '0;
            if (iReady) begin
              oValid  <= 1'b0;
              oReady  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          oReady  <= 1'b1;
          oValid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfmul_digit_serial.sv
// Directed bench for gfmul_digit_serial against hand vectors and a bitwise GCM multiply model.
module tb_gfmul_digit_serial;

  localparam int DIGIT = 8;
  localparam int LAT   = 128 / DIGIT;
  localparam logic [127:0] RPOLY = {8'hE1, 120'd0};

  localparam logic [127:0] KEY_H  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] TC2_C  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] TC2_Z  = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] ONE_X  = 128'h80000000_00000000_00000000_00000000;
  localparam logic [127:0] X1     = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] X2     = 128'he3aa212f2c02a4e035c17e2329aca12e;
  localparam logic [127:0] X3     = 128'h21d514b25466931c7d8f6a5aac84aa05;

  logic         iClk;
  logic         iRst_n;
  logic         iValid;
  logic         oReady;
  logic [127:0] iX;
  logic [127:0] iH;
  logic         iAccum;
  logic         iClear;
  logic         oValid;
  logic         iReady;
  logic [127:0] oResult;

  int n_checks;
  int n_errors;

  gfmul_digit_serial #(
    .DIGIT (DIGIT)
  ) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iValid  (iValid),
    .oReady  (oReady),
    .iX      (iX),
    .iH      (iH),
    .iAccum  (iAccum),
    .iClear  (iClear),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Reference GCM multiply: leftmost hex bit is x^0.
  function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] h);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = h;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ RPOLY;
      else      v = v >> 1;
    end
    return z;
  endfunction

  task automatic run_mul(input logic [127:0] x, input logic [127:0] h, input logic acc,
                         input logic clr, input logic clr_busy,
                         output logic [127:0] res, output int lat);
    @(negedge iClk);
    iX = x; iH = h; iAccum = acc; iClear = clr; iValid = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0; iClear = 1'b0; iAccum = 1'b0; iX = '0; iH = '0;
    lat = 0;
    while (!oValid && lat < 400) begin
      iClear = clr_busy && (lat == 0);
      @(posedge iClk); #1;
      lat++;
    end
    iClear = 1'b0;
    res = oResult;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (!oReady && w < 20) begin
      @(posedge iClk); #1;
      iClear = 1'b0;
      w++;
    end
    iClear = 1'b0;
    chk(tag, {127'd0, oReady}, 128'd1);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] held;
    logic [127:0] ra;
    int           lat;
    logic         spurious;

    n_checks = 0;
    n_errors = 0;
    iRst_n = 1'b0; iValid = 1'b0; iX = '0; iH = '0;
    iAccum = 1'b0; iClear = 1'b0; iReady = 1'b1;
    #23;
    chk("rst_ready",  {127'd0, oReady}, 128'd1);
    chk("rst_valid",  {127'd0, oValid}, 128'd0);
    chk("rst_result", oResult, 128'd0);
    @(negedge iClk); iRst_n = 1'b1;

    run_mul(ONE_X, KEY_H, 1'b0, 1'b0, 1'b0, res, lat);
    chk("ident_res", res, KEY_H);
    chk("ident_model", res, gmul(ONE_X, KEY_H));
    chk("ident_lat", lat, LAT + 1);
    wait_idle("ident_idle");

    run_mul(TC2_C, KEY_H, 1'b1, 1'b1, 1'b0, res, lat);
    chk("tc2_res", res, TC2_Z);
    chk("tc2_lat", lat, LAT + 1);
    wait_idle("tc2_idle");

    run_mul(TC2_C, 128'd0, 1'b0, 1'b0, 1'b0, res, lat);
    chk("zero_h", res, 128'd0);
    wait_idle("zero_h_idle");
    run_mul(128'd0, KEY_H, 1'b0, 1'b0, 1'b0, res, lat);
    chk("zero_x", res, 128'd0);
    wait_idle("zero_x_idle");
    run_mul(128'd1, 128'd1, 1'b0, 1'b0, 1'b0, res, lat);
    chk("reduce", res, gmul(128'd1, 128'd1));
    wait_idle("reduce_idle");
    ra = {$urandom, $urandom, $urandom, $urandom};
    run_mul(ra, X3, 1'b0, 1'b0, 1'b0, res, lat);
    chk("rand_model", res, gmul(ra, X3));
    wait_idle("rand_idle");

    // Chain: second step clears in BUSY, which must be ignored.
    run_mul(X1, KEY_H, 1'b1, 1'b1, 1'b0, res, lat);
    chk("chain1", res, gmul(X1, KEY_H));
    wait_idle("chain1_idle");
    run_mul(X2, KEY_H, 1'b1, 1'b0, 1'b1, res, lat);
    chk("chain2", res, gmul(gmul(X1, KEY_H) ^ X2, KEY_H));
    wait_idle("chain2_idle");
    run_mul(X3, KEY_H, 1'b1, 1'b1, 1'b0, res, lat);
    chk("chain_clr", res, gmul(X3, KEY_H));
    wait_idle("chain_clr_idle");

    run_mul(X1, KEY_H, 1'b0, 1'b0, 1'b0, res, lat);
    chk("plain_mul", res, gmul(X1, KEY_H));
    wait_idle("plain_idle");
    run_mul(X2, KEY_H, 1'b1, 1'b0, 1'b0, res, lat);
    chk("plain_y_upd", res, gmul(gmul(X1, KEY_H) ^ X2, KEY_H));
    iClear = 1'b1;
    wait_idle("done_clr_idle");
    run_mul(X3, KEY_H, 1'b1, 1'b0, 1'b0, res, lat);
    chk("done_clr", res, gmul(X3, KEY_H));
    wait_idle("done_clr2_idle");
    @(negedge iClk); iClear = 1'b1;
    @(negedge iClk); iClear = 1'b0;
    run_mul(X1, KEY_H, 1'b1, 1'b0, 1'b0, res, lat);
    chk("idle_clr", res, gmul(X1, KEY_H));
    wait_idle("idle_clr_idle");

    iReady = 1'b0;
    run_mul(X2, X3, 1'b0, 1'b0, 1'b0, res, lat);
    held = gmul(X2, X3);
    chk("bp_res", res, held);
    for (int i = 0; i < 10; i++) begin
      iValid = 1'b1;
      iX = X1;
      iH = KEY_H;
      @(posedge iClk); #1;
      chk("bp_valid", {127'd0, oValid}, 128'd1);
      chk("bp_stable", oResult, held);
      chk("bp_ready", {127'd0, oReady}, 128'd0);
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    chk("bp_rel_ready", {127'd0, oReady}, 128'd1);
    chk("bp_rel_valid", {127'd0, oValid}, 128'd0);
    @(posedge iClk); #1;
    chk("bp_no_accept", {127'd0, oReady}, 128'd1);

    @(negedge iClk);
    iX = X1; iH = KEY_H; iAccum = 1'b0; iValid = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    repeat (LAT / 2) @(posedge iClk);
    #1 iRst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  {127'd0, oReady}, 128'd1);
    chk("mid_rst_valid",  {127'd0, oValid}, 128'd0);
    chk("mid_rst_result", oResult, 128'd0);
    @(negedge iClk); iRst_n = 1'b1;
    spurious = 1'b0;
    repeat (3 * LAT + 5) begin
      @(posedge iClk); #1;
      if (oValid) spurious = 1'b1;
    end
    chk("no_spurious", {127'd0, spurious}, 128'd0);
    run_mul(X2, KEY_H, 1'b1, 1'b0, 1'b0, res, lat);
    chk("post_rst", res, gmul(X2, KEY_H));
    wait_idle("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
